// File: rtl/cpi_scheduler.sv
// CPI sequencer: arms on a PMT rising edge, emits cpilen PRT-spaced switch toggles, then an optional gap.
// Optional ARM-state PMT timeout (-> FAULT) is enabled by defining PMT_TIMEOUT_EN.
module cpi_scheduler #(
  parameter int PRT_W      = 12,
  parameter int CPI_W      = 8,
  parameter int DEF_PRT    = 2400,
  parameter int DEF_DELAY  = 9,
  parameter int DEF_CPILEN = 100,
  parameter int DEF_GAP    = 0,
  parameter int TIMEOUT    = 4800
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pmt,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [PRT_W-1:0] cfg_prt,
  input  logic [PRT_W-1:0] cfg_delay,
  input  logic [CPI_W-1:0] cfg_cpilen,
  input  logic [PRT_W-1:0] cfg_gap,
  output logic             cfg_err,
  output logic             switch,
  output logic             prt_strobe,
  output logic             cpi_start,
  output logic             cpi_done,
  output logic [CPI_W-1:0] pulse_idx,
  output logic             busy,
  output logic             fault
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_COUNT, S_GAP, S_FAULT} state_t;

  state_t           state, state_nx;
  logic             pmt_q;
  logic [PRT_W-1:0] cnt;
  logic [PRT_W-1:0] act_prt, act_delay, act_gap;
  logic [CPI_W-1:0] act_cpilen;
  logic [PRT_W-1:0] sh_prt, sh_delay, sh_gap;
  logic [CPI_W-1:0] sh_cpilen;
  logic             sh_full;

  logic             pmt_edge, terminal, last, gap_end, apply, cfg_ok, accept, reject, tmo_hit;
  logic [PRT_W-1:0] per_m1, nxt_gap;

  assign pmt_edge = pmt & ~pmt_q;
  assign per_m1   = act_prt - act_delay - PRT_W'(1);
  assign terminal = (state == S_COUNT) && (cnt == per_m1);
  assign last     = terminal && (pulse_idx == act_cpilen - CPI_W'(1));
  assign gap_end  = (state == S_GAP) && (cnt == act_gap - PRT_W'(1));

  // Shadow moves to active only where no running interval can observe it.
  assign apply   = sh_full && ((state == S_IDLE) || ((state == S_ARM) && !pmt_edge) || last);
  assign nxt_gap = apply ? sh_gap : act_gap;

  assign cfg_ok = (cfg_prt > cfg_delay) && (cfg_cpilen != '0);
  assign accept = cfg_valid && !sh_full && cfg_ok;
  assign reject = cfg_valid && !sh_full && !cfg_ok;

  assign cfg_ready = ~sh_full;
  assign busy      = (state == S_COUNT) || (state == S_GAP);

`ifdef PMT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tcnt;

  assign tmo_hit = (state == S_ARM) && (tcnt == TMO_W'(TIMEOUT - 1));
  assign fault   = (state == S_FAULT);

  always_ff @(posedge sysclk) begin
    if (rst)                             tcnt <= '0;
    else if (state == S_ARM && !pmt_edge) tcnt <= tcnt + TMO_W'(1);
    else                                 tcnt <= '0;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT == 0);
  assign tmo_hit    = 1'b0;
  assign fault      = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (enable) state_nx = S_ARM;
      S_ARM: begin
        if (!enable)       state_nx = S_IDLE;
        else if (pmt_edge) state_nx = S_COUNT;
        else if (tmo_hit)  state_nx = S_FAULT;
      end
      S_COUNT: begin
        // enable is only honoured once the CPI has finished
        if (last) begin
          if (nxt_gap != '0) state_nx = S_GAP;
          else if (enable)   state_nx = S_ARM;
          else               state_nx = S_IDLE;
        end
      end
      S_GAP:   if (gap_end) state_nx = enable ? S_ARM : S_IDLE;
      S_FAULT: if (!enable) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state      <= S_IDLE;
      pmt_q      <= 1'b0;
      cnt        <= '0;
      act_prt    <= PRT_W'(DEF_PRT);
      act_delay  <= PRT_W'(DEF_DELAY);
      act_cpilen <= CPI_W'(DEF_CPILEN);
      act_gap    <= PRT_W'(DEF_GAP);
      sh_prt     <= '0;
      sh_delay   <= '0;
      sh_cpilen  <= '0;
      sh_gap     <= '0;
      sh_full    <= 1'b0;
      cfg_err    <= 1'b0;
      switch     <= 1'b0;
      prt_strobe <= 1'b0;
      cpi_start  <= 1'b0;
      cpi_done   <= 1'b0;
      pulse_idx  <= '0;
    end else begin
      state      <= state_nx;
      pmt_q      <= pmt;
      cfg_err    <= reject;
      prt_strobe <= 1'b0;
      cpi_start  <= 1'b0;
      cpi_done   <= 1'b0;

      if (apply) begin
        act_prt    <= sh_prt;
        act_delay  <= sh_delay;
        act_cpilen <= sh_cpilen;
        act_gap    <= sh_gap;
      end

      if (accept) begin
        sh_prt    <= cfg_prt;
        sh_delay  <= cfg_delay;
        sh_cpilen <= cfg_cpilen;
        sh_gap    <= cfg_gap;
        sh_full   <= 1'b1;
      end else if (apply) begin
        sh_full   <= 1'b0;
      end

      case (state)
        S_ARM: begin
          cnt <= '0;
          if (state_nx == S_COUNT) begin
            cpi_start <= 1'b1;
            pulse_idx <= '0;
            switch    <= 1'b0;
          end
        end
        S_COUNT: begin
          if (terminal) begin
            cnt        <= '0;
            prt_strobe <= 1'b1;
            cpi_done   <= last;
            switch     <= last ? 1'b0 : ~switch;
            pulse_idx  <= (pulse_idx == act_cpilen) ? pulse_idx : pulse_idx + CPI_W'(1);
          end else begin
            cnt <= cnt + PRT_W'(1);
          end
        end
        S_GAP:   cnt <= cnt + PRT_W'(1);
        default: begin
          cnt    <= '0;
          switch <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpi_scheduler.sv
// Directed bench for cpi_scheduler: handshake vector table plus hand-written CPI timing sequences.
module tb_cpi_scheduler;
  localparam int PRT_W = 12;
  localparam int CPI_W = 8;

  logic             sysclk, rst, enable, pmt, cfg_valid;
  logic             cfg_ready, cfg_err, switch, prt_strobe, cpi_start, cpi_done, busy, fault;
  logic [PRT_W-1:0] cfg_prt, cfg_delay, cfg_gap;
  logic [CPI_W-1:0] cfg_cpilen, pulse_idx;

  int checks   = 0;
  int failures = 0;

  cpi_scheduler #(.PRT_W(PRT_W), .CPI_W(CPI_W), .TIMEOUT(50)) dut (
    .sysclk(sysclk), .rst(rst), .enable(enable), .pmt(pmt),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_prt(cfg_prt), .cfg_delay(cfg_delay),
    .cfg_cpilen(cfg_cpilen), .cfg_gap(cfg_gap), .cfg_err(cfg_err), .switch(switch),
    .prt_strobe(prt_strobe), .cpi_start(cpi_start), .cpi_done(cpi_done),
    .pulse_idx(pulse_idx), .busy(busy), .fault(fault)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_cfg(input bit v, input int p, input int d, input int l, input int g);
    cfg_valid  = v;
    cfg_prt    = PRT_W'(p);
    cfg_delay  = PRT_W'(d);
    cfg_cpilen = CPI_W'(l);
    cfg_gap    = PRT_W'(g);
  endtask

  // One CPI from the arming edge: expected strobe/switch/done/busy derived from period, count and gap.
  task automatic run_cpi(input int per, input int n, input int gap, input bit wr, input bit drop);
    int  total;
    bit  sw, stb;
    total = per * n;
    sw    = 1'b0;
    pmt   = 1'b1;
    tick();
    chk("cpi_start", cpi_start, 1);
    chk("busy_at_start", busy, 1);
    pmt = 1'b0;
    for (int k = 1; k <= total + gap + 1; k++) begin
      tick();
      stb = (k <= total) && (k % per == 0);
      if (stb) sw = (k == total) ? 1'b0 : ~sw;
      chk("prt_strobe", prt_strobe, stb);
      chk("switch", switch, sw);
      chk("cpi_done", cpi_done, k == total);
      chk("busy", busy, k < total + gap);
      if (stb) chk("pulse_idx", pulse_idx, k / per);
      if (wr && k == 3) set_cfg(1, 30, 2, 4, 0);
      if (wr && k == 4) begin
        chk("ready_after_accept", cfg_ready, 0);
        cfg_valid = 1'b0;
      end
      if (wr && k == total - 1) chk("ready_held_in_cpi", cfg_ready, 0);
      if (wr && k == total)     chk("ready_after_done", cfg_ready, 1);
      if (drop && k == 10) enable = 1'b0;
    end
  endtask

  typedef struct {
    logic en, pm, vld;
    int   prt, dly, len, gap;
    logic e_rdy, e_err, e_busy, e_start;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{0, 1, 0, 20, 2, 4, 0, 1, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 20, 2, 4, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 0, 20, 2, 4, 0, 1, 0, 0, 0};
    tbl[3] = '{0, 0, 1,  5, 5, 4, 0, 1, 1, 0, 0};
    tbl[4] = '{0, 0, 0,  5, 5, 4, 0, 1, 0, 0, 0};
    tbl[5] = '{0, 0, 1, 20, 2, 0, 0, 1, 1, 0, 0};
    tbl[6] = '{0, 0, 1,  3, 7, 4, 0, 1, 1, 0, 0};
    tbl[7] = '{0, 0, 1, 20, 2, 4, 0, 0, 0, 0, 0};
    tbl[8] = '{0, 0, 1, 20, 2, 4, 0, 1, 0, 0, 0};
    tbl[9] = '{0, 0, 0, 20, 2, 4, 0, 1, 0, 0, 0};

    rst = 1'b1; enable = 1'b0; pmt = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_ready", cfg_ready, 1);
    chk("rst_switch", switch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fault", fault, 0);
    chk("rst_pulse_idx", pulse_idx, 0);
    chk("rst_outs", {cfg_err, prt_strobe, cpi_start, cpi_done}, 0);
    rst = 1'b0;

    // Handshake vectors while idle; pmt edges must be ignored here.
    for (int i = 0; i < 10; i++) begin
      enable = tbl[i].en;
      pmt    = tbl[i].pm;
      set_cfg(tbl[i].vld, tbl[i].prt, tbl[i].dly, tbl[i].len, tbl[i].gap);
      tick();
      chk($sformatf("vec%0d_ready", i), cfg_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_err", i), cfg_err, tbl[i].e_err);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_start", i), cpi_start, tbl[i].e_start);
    end
    cfg_valid = 1'b0;
    pmt = 1'b0;

    // Active is 20/2/4/0 (rejects left it alone): 18-cycle period, mid-CPI write of prt=30.
    enable = 1'b1;
    tick();
    chk("arm_not_busy", busy, 0);
    run_cpi(18, 4, 0, 1, 0);
    run_cpi(28, 4, 0, 0, 0);

    // Gap config applied while armed.
    set_cfg(1, 20, 2, 4, 10);
    tick();
    cfg_valid = 1'b0;
    tick();
    chk("gap_cfg_ready", cfg_ready, 1);
    chk("gap_cfg_err", cfg_err, 0);
    run_cpi(18, 4, 10, 0, 1);

    // Back in IDLE: a later pmt edge must not start anything.
    pmt = 1'b1;
    tick();
    pmt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_no_start", cpi_start, 0);
      chk("idle_not_busy", busy, 0);
    end

    // Arm with no pmt for the timeout window.
    enable = 1'b1;
    tick();
    repeat (49) tick();
    chk("fault_before_timeout", fault, 0);
    tick();
`ifdef PMT_TIMEOUT_EN
    chk("fault_at_timeout", fault, 1);
`else
    chk("fault_tied_low", fault, 0);
`endif
    chk("fault_switch", switch, 0);
    enable = 1'b0;
    tick();
    chk("fault_cleared", fault, 0);
    chk("fault_exit_busy", busy, 0);

    // Reset in the middle of a CPI.
    enable = 1'b1;
    tick();
    pmt = 1'b1;
    tick();
    pmt = 1'b0;
    repeat (18) tick();
    chk("pre_rst_switch", switch, 1);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("midrst_switch", switch, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cfg_ready, 1);
    chk("midrst_pulse_idx", pulse_idx, 0);
    rst = 1'b0;
    enable = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
